// File: rtl/shared_mem_arbiter.sv
// rtl/shared_mem_arbiter.sv - shared-bus responder: arbitrates cores onto global memory or device port
// Define SHARED_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest index wins.
module shared_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int GMEM_SIZE = 8192
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [16*NUM_CORES-1:0] core_addr,
  input  logic [NUM_CORES-1:0]    core_wren,
  input  logic [NUM_CORES-1:0]    core_rden,
  input  logic [16*NUM_CORES-1:0] core_write_val,
  output logic [NUM_CORES-1:0]    core_ready,
  output logic [15:0]             core_read_val,
  output logic [15:0]             dev_addr,
  output logic                    dev_wren,
  output logic                    dev_rden,
  output logic [15:0]             dev_write_val,
  input  logic [15:0]             dev_read_val
);

  localparam int PW = $clog2(NUM_CORES);
  localparam int GW = $clog2(GMEM_SIZE);

  logic [NUM_CORES-1:0] req;
  logic [NUM_CORES-1:0] grant;
  logic                 grant_valid;
  logic [PW-1:0]        grant_idx;

  logic [15:0]          g_addr;
  logic [15:0]          g_wdata;
  logic                 g_wr;
  logic                 g_rd;
  logic                 g_is_dev;
  logic [15:0]          g_offset;
  logic [GW-1:0]        g_index;

  logic [15:0]          mem [GMEM_SIZE];

  assign req = core_wren | core_rden;

`ifdef SHARED_ARB_ROUND_ROBIN_EN
  logic [PW-1:0] rr_ptr;
  int            cand;

  // Scan upward from rr_ptr, wrapping at NUM_CORES; first requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_CORES) cand = cand - NUM_CORES;
      if (!grant_valid && req[PW'(cand)]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(cand);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == PW'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
`else
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = NUM_CORES - 1; k >= 0; k--) begin
      if (req[k]) begin
        grant_valid = 1'b1;
        grant_idx   = PW'(k);
      end
    end
  end
`endif

  // No grants while reset is held, so nothing can be committed at that edge.
  always_comb begin
    grant = '0;
    if (grant_valid && reset) grant[grant_idx] = 1'b1;
  end

  assign core_ready = ~req | grant;

  // Route the granted core's request; core 0's address/data show when idle.
  always_comb begin
    g_addr  = core_addr[15:0];
    g_wdata = core_write_val[15:0];
    g_wr    = 1'b0;
    g_rd    = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant[i]) begin
        g_addr  = core_addr[16*i +: 16];
        g_wdata = core_write_val[16*i +: 16];
        g_wr    = core_wren[i];
        g_rd    = core_rden[i] & ~core_wren[i];
      end
    end
  end

  assign g_is_dev = (g_addr[15:14] == 2'b11);
  assign g_offset = g_addr - 16'h4000;
  assign g_index  = g_offset[GW-1:0];

  assign dev_addr      = g_addr;
  assign dev_write_val = g_wdata;
  assign dev_wren      = g_wr & g_is_dev;
  assign dev_rden      = g_rd & g_is_dev;

  always_ff @(posedge clk) begin
    if (g_wr && !g_is_dev) mem[g_index] <= g_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      core_read_val <= '0;
    end else if (g_rd) begin
      core_read_val <= g_is_dev ? dev_read_val : mem[g_index];
    end
  end

endmodule
